// File: rtl/calc_controller.sv
// Pocket-calculator sequencer: turns key tokens into ALU operations and drives
// the display and error lamp. One token per cycle; the ALU runs its own latency.
module calc_controller #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    output logic [1:0]       o_alu_op,
    output logic             o_alu_start,
    input  logic             i_alu_done,
    input  logic [WIDTH-1:0] i_alu_result,
    input  logic             i_alu_error,
    output logic [WIDTH-1:0] o_display,
    output logic             o_error
);

    typedef enum logic [2:0] {ENTER_A, OP, ENTER_B, BUSY, RESULT, ERROR} state_t;

    localparam logic [4:0]       TOK_AC = 5'd10;
    localparam logic [4:0]       TOK_EQ = 5'd15;
    localparam logic [WIDTH+3:0] MAXV   = {4'd0, {WIDTH{1'b1}}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [WIDTH-1:0] disp_q, disp_d;
    logic [1:0]       op_q, op_d, pend_op_q, pend_op_d, alu_op_q, alu_op_d;
    logic             pend_q, pend_d, start_q, start_d;

    logic             take, is_digit, is_oper;
    logic [4:0]       tok_off;
    logic [1:0]       tok_op;
    logic [3:0]       digit;
    logic [WIDTH+3:0] acc_a, acc_b;

    // X*10+d computed wide so overflow past 2^WIDTH-1 is visible
    function automatic logic [WIDTH+3:0] accum(input logic [WIDTH-1:0] x, input logic [3:0] d);
        logic [WIDTH+3:0] xw;
        xw = {4'd0, x};
        return (xw << 3) + (xw << 1) + {{WIDTH{1'b0}}, d};
    endfunction

    assign take     = i_valid && (state_q != BUSY);
    assign is_digit = (i_data <= 5'd9);
    assign is_oper  = (i_data >= 5'd11) && (i_data <= 5'd14);
    assign tok_off  = i_data - 5'd11;
    assign tok_op   = tok_off[1:0];
    assign digit    = i_data[3:0];
    assign acc_a    = accum(a_q, digit);
    assign acc_b    = accum(b_q, digit);

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        pend_d    = pend_q;
        pend_op_d = pend_op_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        start_d   = 1'b0;

        if (state_q == BUSY) begin
            if (i_alu_done) begin
                if (i_alu_error) begin
                    state_d = ERROR;
                end else begin
                    a_d = i_alu_result;
                    b_d = '0;
                    if (pend_q) begin
                        op_d    = pend_op_q;
                        pend_d  = 1'b0;
                        state_d = OP;
                    end else begin
                        state_d = RESULT;
                    end
                end
            end
        end else if (take) begin
            if (i_data == TOK_AC) begin
                a_d       = '0;
                b_d       = '0;
                op_d      = 2'b00;
                pend_d    = 1'b0;
                pend_op_d = 2'b00;
                state_d   = ENTER_A;
            end else if (state_q == ERROR) begin
                state_d = ERROR;
            end else if (is_digit) begin
                case (state_q)
                    ENTER_A: if (acc_a <= MAXV) a_d = acc_a[WIDTH-1:0];
                    ENTER_B: if (acc_b <= MAXV) b_d = acc_b[WIDTH-1:0];
                    OP: begin
                        b_d     = WIDTH'(digit);
                        state_d = ENTER_B;
                    end
                    RESULT: begin
                        a_d     = WIDTH'(digit);
                        state_d = ENTER_A;
                    end
                    default: ;
                endcase
            end else if (is_oper || i_data == TOK_EQ) begin
                if (state_q == ENTER_B) begin
                    // launch with the stored opcode; a new operator waits as pending
                    pend_d    = is_oper;
                    pend_op_d = is_oper ? tok_op : 2'b00;
                    alu_a_d   = a_q;
                    alu_b_d   = b_q;
                    alu_op_d  = op_q;
                    start_d   = 1'b1;
                    state_d   = BUSY;
                end else if (is_oper) begin
                    op_d    = tok_op;
                    state_d = OP;
                end
            end
        end

        case (state_d)
            ENTER_B: disp_d = b_d;
            ERROR:   disp_d = '0;
            default: disp_d = a_d;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ENTER_A;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= 2'b00;
            pend_q    <= 1'b0;
            pend_op_q <= 2'b00;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= 2'b00;
            start_q   <= 1'b0;
            disp_q    <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            pend_q    <= pend_d;
            pend_op_q <= pend_op_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            start_q   <= start_d;
            disp_q    <= disp_d;
        end
    end

    assign o_ready     = (state_q != BUSY);
    assign o_alu_a     = alu_a_q;
    assign o_alu_b     = alu_b_q;
    assign o_alu_op    = alu_op_q;
    assign o_alu_start = start_q;
    assign o_display   = disp_q;
    assign o_error     = (state_q == ERROR);

endmodule

// File: tb/tb_calc_controller.sv
// Bench for calc_controller: directed calculator scenarios with literal
// expectations, then random key/ALU traffic against a behavioural model.
module tb_calc_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  i_data;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] o_alu_a, o_alu_b, o_display, i_alu_result;
    logic [1:0]  o_alu_op;
    logic        o_alu_start, i_alu_done, i_alu_error, o_error;

    int checks = 0;
    int failures = 0;

    calc_controller #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op), .o_alu_start(o_alu_start),
        .i_alu_done(i_alu_done), .i_alu_result(i_alu_result), .i_alu_error(i_alu_error),
        .o_display(o_display), .o_error(o_error)
    );

    always #5 clk = ~clk;

    // Behavioural model: calculator mode plus operand registers as plain ints
    localparam int M_A = 0, M_OP = 1, M_B = 2, M_BUSY = 3, M_RES = 4, M_ERR = 5;
    int m_mode, mA, mB, mop, mpv, mpo, ma, mb, mo, mstart;

    task automatic model_reset();
        m_mode = M_A; mA = 0; mB = 0; mop = 0; mpv = 0; mpo = 0;
        ma = 0; mb = 0; mo = 0; mstart = 0;
    endtask

    task automatic model_step(input int t, input bit v, input bit d, input int r, input bit e);
        mstart = 0;
        if (m_mode == M_BUSY) begin
            if (d) begin
                if (e) m_mode = M_ERR;
                else begin
                    mA = r; mB = 0;
                    if (mpv != 0) begin mop = mpo; mpv = 0; m_mode = M_OP; end
                    else m_mode = M_RES;
                end
            end
        end else if (v) begin
            if (t == 10) begin
                mA = 0; mB = 0; mop = 0; mpv = 0; mpo = 0; m_mode = M_A;
            end else if (m_mode == M_ERR) begin
            end else if (t <= 9) begin
                if (m_mode == M_A && mA * 10 + t <= 65535) mA = mA * 10 + t;
                else if (m_mode == M_B && mB * 10 + t <= 65535) mB = mB * 10 + t;
                else if (m_mode == M_OP) begin mB = t; m_mode = M_B; end
                else if (m_mode == M_RES) begin mA = t; m_mode = M_A; end
            end else if (t >= 11 && t <= 15) begin
                if (m_mode == M_B) begin
                    mpv = (t != 15); mpo = (t != 15) ? t - 11 : 0;
                    ma = mA; mb = mB; mo = mop; mstart = 1; m_mode = M_BUSY;
                end else if (t != 15) begin
                    mop = t - 11; m_mode = M_OP;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        chk("ready",   32'(o_ready),     32'(m_mode != M_BUSY));
        chk("start",   32'(o_alu_start), 32'(mstart));
        chk("alu_a",   32'(o_alu_a),     32'(ma));
        chk("alu_b",   32'(o_alu_b),     32'(mb));
        chk("alu_op",  32'(o_alu_op),    32'(mo));
        chk("error",   32'(o_error),     32'(m_mode == M_ERR));
        chk("display", 32'(o_display),   (m_mode == M_B) ? 32'(mB) : (m_mode == M_ERR) ? 32'd0 : 32'(mA));
    endtask

    // Inputs applied at the falling edge, model advanced at the rising edge,
    // outputs compared at the next falling edge.
    task automatic cycle(input int t, input bit v, input bit d, input int r, input bit e);
        i_data = 5'(t); i_valid = v; i_alu_done = d; i_alu_result = 16'(r); i_alu_error = e;
        @(posedge clk);
        model_step(t, v, d, r, e);
        @(negedge clk);
        cmp_model();
    endtask

    task automatic tok(input int t);
        cycle(t, 1'b1, 1'b0, 0, 1'b0);
    endtask

    task automatic done(input int r, input bit e);
        cycle(0, 1'b0, 1'b1, r, e);
    endtask

    initial begin
        rst_n = 1'b0; i_data = '0; i_valid = 1'b0; i_alu_done = 1'b0;
        i_alu_result = '0; i_alu_error = 1'b0;
        model_reset();
        @(negedge clk);
        cmp_model();
        chk("rst_display", 32'(o_display), 32'd0);
        chk("rst_ready",   32'(o_ready),   32'd1);
        rst_n = 1'b1;

        // 12 + 3 = 15
        tok(1); tok(2); tok(11); tok(3); tok(15);
        chk("add_start", 32'(o_alu_start), 32'd1);
        chk("add_a", 32'(o_alu_a), 32'd12);
        chk("add_b", 32'(o_alu_b), 32'd3);
        chk("add_op", 32'(o_alu_op), 32'd0);
        done(15, 1'b0);
        chk("add_disp", 32'(o_display), 32'd15);
        chk("add_ready", 32'(o_ready), 32'd1);

        // chained 5 + 3 * 2
        tok(10); tok(5); tok(11); tok(3); tok(13);
        chk("chain_a1", 32'(o_alu_a), 32'd5);
        chk("chain_op1", 32'(o_alu_op), 32'd0);
        done(8, 1'b0);
        chk("chain_disp8", 32'(o_display), 32'd8);
        tok(2); tok(15);
        chk("chain_start2", 32'(o_alu_start), 32'd1);
        chk("chain_a2", 32'(o_alu_a), 32'd8);
        chk("chain_b2", 32'(o_alu_b), 32'd2);
        chk("chain_op2", 32'(o_alu_op), 32'd2);
        done(16, 1'b0);
        chk("chain_disp16", 32'(o_display), 32'd16);

        // accumulation saturates at the width boundary
        tok(10); tok(6); tok(5); tok(5); tok(3); tok(5); tok(0);
        chk("max_disp", 32'(o_display), 32'd65535);

        // divide by zero, error lock-out, AC recovery
        tok(10); tok(9); tok(14); tok(0); tok(15);
        done(0, 1'b1);
        chk("err_flag", 32'(o_error), 32'd1);
        chk("err_disp", 32'(o_display), 32'd0);
        tok(7); tok(11);
        chk("err_hold", 32'(o_error), 32'd1);
        tok(10);
        chk("ac_err", 32'(o_error), 32'd0);
        chk("ac_disp", 32'(o_display), 32'd0);

        // tokens held valid through a slow ALU
        tok(6); tok(12); tok(2); tok(15);
        for (int i = 0; i < 5; i++) begin
            cycle(7, 1'b1, 1'b0, 0, 1'b0);
            chk("busy_ready", 32'(o_ready), 32'd0);
            chk("busy_a", 32'(o_alu_a), 32'd6);
            chk("busy_op", 32'(o_alu_op), 32'd1);
        end
        cycle(7, 1'b1, 1'b1, 4, 1'b0);
        chk("slow_disp", 32'(o_display), 32'd4);
        cycle(7, 1'b1, 1'b0, 0, 1'b0);
        chk("slow_next", 32'(o_display), 32'd7);

        // reset in the middle of an operation
        tok(10); tok(4); tok(11); tok(5); tok(15); tok(3);
        rst_n = 1'b0;
        #1;
        model_reset();
        cmp_model();
        chk("mid_rst_alu_a", 32'(o_alu_a), 32'd0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        done(9, 1'b0);
        chk("post_rst_disp", 32'(o_display), 32'd0);
        chk("post_rst_ready", 32'(o_ready), 32'd1);

        // random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            int p, t, r;
            bit v, d, e;
            p = int'($urandom_range(0, 99));
            if (p < 50)      t = int'($urandom_range(0, 9));
            else if (p < 75) t = int'($urandom_range(11, 14));
            else if (p < 85) t = 15;
            else if (p < 90) t = 10;
            else             t = int'($urandom_range(16, 31));
            v = ($urandom_range(0, 3) != 0);
            d = (m_mode == M_BUSY) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            case (mo)
                0: r = (ma + mb) & 16'hFFFF;
                1: r = (ma - mb) & 16'hFFFF;
                2: r = (ma * mb) & 16'hFFFF;
                default: r = (mb == 0) ? 0 : ma / mb;
            endcase
            e = ($urandom_range(0, 9) == 0) || (mo == 3 && mb == 0);
            cycle(t, v, d, r, e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/calc_controller.md
CALC_CONTROLLER -- requirements
Module: calc_controller

Interface
REQ-001 SHALL have parameter: WIDTH, 16, operand/result width in bits (unsigned).
REQ-002 SHALL have ports, one per line:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_data  in  5  key token from button reader.
- i_valid  in  1  token valid.
- o_ready  out  1  controller can accept a token.
- o_alu_a  out  WIDTH  ALU operand A.
- o_alu_b  out  WIDTH  ALU operand B.
- o_alu_op  out  2  ALU opcode: 00 add, 01 sub, 10 mul, 11 div.
- o_alu_start  out  1  one-cycle ALU start pulse.
- i_alu_done  in  1  ALU result valid, one-cycle pulse.
- i_alu_result  in  WIDTH  ALU result.
- i_alu_error  in  1  ALU error (div-by-zero, overflow), qualified by i_alu_done.
- o_display  out  WIDTH  value to show.
- o_error  out  1  error indicator.

Function
REQ-003 Token codes SHALL be: 0-9 digit, 10 AC, 11 ADD, 12 SUB, 13 MUL, 14 DIV, 15 EQ; codes 16-31 SHALL be accepted and discarded with no state change.
REQ-004 A token SHALL be consumed only in a cycle with i_valid=1 and o_ready=1; at most one token per cycle.
REQ-005 o_ready SHALL be 1 in every state except BUSY, where it SHALL be 0.
REQ-006 States SHALL be: ENTER_A, OP, ENTER_B, BUSY, RESULT, ERROR.
REQ-007 Digit accumulation SHALL compute X*10+d in WIDTH+4 bits; if the result exceeds 2^WIDTH-1, the digit SHALL be discarded and X unchanged.
REQ-008 ENTER_A: digit accumulates into A; ADD/SUB/MUL/DIV store opcode, go OP; EQ no change.
REQ-009 OP: digit sets B=d, go ENTER_B; operator replaces stored opcode; EQ discarded.
REQ-010 ENTER_B: digit accumulates into B; operator or EQ go BUSY, recording the pending next operator (if operator) or none (if EQ).
REQ-011 On entry to BUSY, o_alu_a=A, o_alu_b=B, o_alu_op=stored opcode SHALL be registered and held stable until BUSY exits; o_alu_start SHALL be 1 exactly in the first BUSY cycle.
REQ-012 BUSY: i_alu_done SHALL be honoured in any BUSY cycle including the start cycle; i_alu_done outside BUSY SHALL be ignored.
REQ-013 On done with i_alu_error=1: go ERROR. Otherwise A=i_alu_result, B=0; if pending operator exists, opcode=pending, go OP; else go RESULT.
REQ-014 RESULT: digit sets A=d, go ENTER_A; operator stores opcode, go OP; EQ discarded.
REQ-015 ERROR: o_error=1; all tokens except AC SHALL be consumed and discarded.
REQ-016 AC in any non-BUSY state SHALL clear A, B, opcode, pending, o_error and go ENTER_A in the next cycle.
REQ-017 o_display SHALL be B in ENTER_B, 0 in ERROR, A in all other states, registered (updates the cycle after the causing event).
REQ-018 The controller SHALL wait indefinitely in BUSY; there is no timeout.

Reset
REQ-019 rst_n=0 SHALL asynchronously force state ENTER_A, A=B=0, opcode=00, no pending, o_alu_start=0, o_alu_a=o_alu_b=0, o_alu_op=00, o_display=0, o_error=0, o_ready=1 (from deassertion).
REQ-020 Reset asserted during BUSY SHALL abandon the operation; a later i_alu_done SHALL be ignored.

Verification
REQ-021 Tokens 1,2,ADD,3,EQ -> one o_alu_start with a=12,b=3,op=00; done result=15 -> o_display=15, state RESULT, o_ready=1.
REQ-022 Chaining 5,ADD,3,MUL -> start a=5,b=3,op=00; done 8 -> state OP, op=10; then 2,EQ -> start a=8,b=2,op=10; done 16 -> o_display=16.
REQ-023 WIDTH=16, digits 6,5,5,3,5,0 -> A=65535, final 0 discarded, o_display=65535.
REQ-024 9,DIV,0,EQ then done with error=1 -> o_error=1, o_display=0; tokens 7,ADD discarded; AC -> o_error=0, o_display=0, ENTER_A.
REQ-025 i_valid held 1 throughout BUSY with done delayed 5 cycles -> o_ready=0 for those cycles, no token lost or consumed, o_alu_* stable.
REQ-026 rst_n pulsed low mid-BUSY, then i_alu_done=1 -> all outputs at reset values, done ignored, state ENTER_A.
